// File: rtl/chipscope_debug_stats.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : chipscope_debug_stats
// Purpose  : Per-bus debug statistics for the ChipScope/VIO capture block.
//            Timestamps NAND commands on issue, matches completions in order
//            to measure latency, accumulates ECC error counts and tracks
//            outstanding commands. All debug words come straight from flops.
// Ports    : v_clk0            - block clock
//            v_rst0_n          - asynchronous active-low reset
//            v_clear           - synchronous clear of counters, FIFO, flags
//            v_cmd_issue       - pulse: command issued
//            v_cmd_done        - pulse: oldest outstanding command completed
//            v_err_inc         - corrected bit errors this cycle
//            v_err_uncorr      - pulse: uncorrectable page
//            v_dbg_state       - {7'b0, occupancy[4:0], unf, ovf, fsm[1:0]}
//            v_dbg_cmd_cnt     - completed-command count (wraps at 16 bits)
//            v_dbg_latency_64  - {max latency, last latency} in cycles
//            v_dbg_err_64      - {uncorrectable count, corrected-bit total}
// Revision : 1.0 - initial release
// ============================================================================
module chipscope_debug_stats #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ERR_INC_W = 4
) (
    input  logic                 v_clk0,
    input  logic                 v_rst0_n,
    input  logic                 v_clear,
    input  logic                 v_cmd_issue,
    input  logic                 v_cmd_done,
    input  logic [ERR_INC_W-1:0] v_err_inc,
    input  logic                 v_err_uncorr,
    output logic [15:0]          v_dbg_state,
    output logic [15:0]          v_dbg_cmd_cnt,
    output logic [63:0]          v_dbg_latency_64,
    output logic [63:0]          v_dbg_err_64
);

    localparam int unsigned       c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ADDR_W:0] c_FULL   = (c_ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    state_t              r_state;
    logic [31:0]         r_ts;
    logic [31:0]         r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic                r_ovf;
    logic                r_unf;
    logic [15:0]         r_cmd_cnt;
    logic [31:0]         r_lat_last;
    logic [31:0]         r_lat_max;
    logic [47:0]         r_err_corr;
    logic [15:0]         r_err_uncorr;

    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_ovf_evt;
    logic                w_unf_evt;
    logic [31:0]         w_lat;
    logic [c_ADDR_W:0]   w_count_nxt;
    logic [48:0]         w_corr_sum;

    // Pop is judged against the current head first; a pop in the same cycle
    // frees a slot, so a simultaneous push on a full FIFO still lands.
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_FULL);
    assign w_pop       = v_cmd_done && !w_empty;
    assign w_unf_evt   = v_cmd_done && w_empty;
    assign w_push      = v_cmd_issue && (!w_full || w_pop);
    assign w_ovf_evt   = v_cmd_issue && w_full && !w_pop;
    assign w_count_nxt = r_count + (c_ADDR_W + 1)'(w_push) - (c_ADDR_W + 1)'(w_pop);

    // Modular subtraction keeps the latency correct across a timestamp wrap.
    assign w_lat      = r_ts - r_mem[r_rd_ptr];
    assign w_corr_sum = {1'b0, r_err_corr} + 49'(v_err_inc);

    // Timestamp storage; no reset needed since occupancy guards every read.
    always_ff @(posedge v_clk0) begin
        if (w_push && !v_clear) begin
            r_mem[r_wr_ptr] <= r_ts;
        end
    end

    // The timestamp is free-running and deliberately ignores v_clear.
    always_ff @(posedge v_clk0 or negedge v_rst0_n) begin
        if (!v_rst0_n) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 32'd1;
        end
    end

    always_ff @(posedge v_clk0 or negedge v_rst0_n) begin
        if (!v_rst0_n) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
            r_cmd_cnt    <= '0;
            r_lat_last   <= '0;
            r_lat_max    <= '0;
            r_err_corr   <= '0;
            r_err_uncorr <= '0;
        end else if (v_clear) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
            r_cmd_cnt    <= '0;
            r_lat_last   <= '0;
            r_lat_max    <= '0;
            r_err_corr   <= '0;
            r_err_uncorr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_lat_last <= w_lat;
                r_cmd_cnt  <= r_cmd_cnt + 16'd1;
                if (w_lat > r_lat_max) begin
                    r_lat_max <= w_lat;
                end
            end
            r_count <= w_count_nxt;

            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end
            if (w_unf_evt) begin
                r_unf <= 1'b1;
            end

            // Saturating error accumulators.
            if (w_corr_sum[48]) begin
                r_err_corr <= '1;
            end else begin
                r_err_corr <= w_corr_sum[47:0];
            end
            if (v_err_uncorr && (r_err_uncorr != 16'hFFFF)) begin
                r_err_uncorr <= r_err_uncorr + 16'd1;
            end

            // FAULT is sticky until clear/reset; otherwise follow occupancy.
            if ((r_state == ST_FAULT) || w_ovf_evt || w_unf_evt) begin
                r_state <= ST_FAULT;
            end else if (w_count_nxt != '0) begin
                r_state <= ST_ACTIVE;
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign v_dbg_state      = {7'd0, 5'(r_count), r_unf, r_ovf, r_state};
    assign v_dbg_cmd_cnt    = r_cmd_cnt;
    assign v_dbg_latency_64 = {r_lat_max, r_lat_last};
    assign v_dbg_err_64     = {r_err_uncorr, r_err_corr};

endmodule
`default_nettype wire

// File: tb/tb_chipscope_debug_stats.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_chipscope_debug_stats
// Purpose  : Self-checking bench for chipscope_debug_stats. Directed cases
//            plus randomized traffic, compared every cycle against a
//            queue-based reference model of the statistics block.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chipscope_debug_stats;

    localparam int          DEPTH      = 8;
    localparam int          ERR_INC_W  = 4;
    localparam longint      c_CORR_MAX = 64'h0000_FFFF_FFFF_FFFF;

    logic                 v_clk0 = 1'b0;
    logic                 v_rst0_n = 1'b0;
    logic                 v_clear = 1'b0;
    logic                 v_cmd_issue = 1'b0;
    logic                 v_cmd_done = 1'b0;
    logic [ERR_INC_W-1:0] v_err_inc = '0;
    logic                 v_err_uncorr = 1'b0;
    logic [15:0]          v_dbg_state;
    logic [15:0]          v_dbg_cmd_cnt;
    logic [63:0]          v_dbg_latency_64;
    logic [63:0]          v_dbg_err_64;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    longint      m_cyc;
    longint      m_q[$];
    bit          m_ovf;
    bit          m_unf;
    int          m_cmd;
    logic [31:0] m_last;
    logic [31:0] m_max;
    longint      m_corr;
    int          m_unc;

    chipscope_debug_stats #(
        .DEPTH     (DEPTH),
        .ERR_INC_W (ERR_INC_W)
    ) dut (
        .v_clk0           (v_clk0),
        .v_rst0_n         (v_rst0_n),
        .v_clear          (v_clear),
        .v_cmd_issue      (v_cmd_issue),
        .v_cmd_done       (v_cmd_done),
        .v_err_inc        (v_err_inc),
        .v_err_uncorr     (v_err_uncorr),
        .v_dbg_state      (v_dbg_state),
        .v_dbg_cmd_cnt    (v_dbg_cmd_cnt),
        .v_dbg_latency_64 (v_dbg_latency_64),
        .v_dbg_err_64     (v_dbg_err_64)
    );

    always #5 v_clk0 = ~v_clk0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0;
        m_q.delete();
        m_ovf = 0;
        m_unf = 0;
        m_cmd = 0;
        m_last = '0;
        m_max = '0;
        m_corr = 0;
        m_unc = 0;
    endtask

    // One clock of the block's rules, stated directly on a queue of issue times.
    task automatic model_update(input bit iss, input bit dn, input int inc, input bit unc, input bit clr);
        longint      t_issue;
        logic [31:0] lat;
        if (clr) begin
            m_q.delete();
            m_ovf = 0;
            m_unf = 0;
            m_cmd = 0;
            m_last = '0;
            m_max = '0;
            m_corr = 0;
            m_unc = 0;
        end else begin
            if (dn) begin
                if (m_q.size() > 0) begin
                    t_issue = m_q.pop_front();
                    lat = 32'(m_cyc - t_issue);
                    m_last = lat;
                    if (lat > m_max) m_max = lat;
                    m_cmd = (m_cmd + 1) % 65536;
                end else begin
                    m_unf = 1;
                end
            end
            if (iss) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_cyc);
                else m_ovf = 1;
            end
            m_corr = m_corr + inc;
            if (m_corr > c_CORR_MAX) m_corr = c_CORR_MAX;
            if (unc && m_unc < 65535) m_unc++;
        end
        m_cyc++;
    endtask

    function automatic logic [15:0] exp_state();
        logic [1:0] code;
        logic [4:0] occ;
        occ = 5'(m_q.size());
        if (m_ovf || m_unf) code = 2'd2;
        else if (m_q.size() > 0) code = 2'd1;
        else code = 2'd0;
        return {7'd0, occ, m_unf, m_ovf, code};
    endfunction

    task automatic compare_all();
        check_val("state", 64'(v_dbg_state), 64'(exp_state()));
        check_val("cmd_cnt", 64'(v_dbg_cmd_cnt), 64'(m_cmd));
        check_val("latency", v_dbg_latency_64, {m_max, m_last});
        check_val("err", v_dbg_err_64, {16'(m_unc), 48'(m_corr)});
    endtask

    // Drive at the falling edge, let one rising edge sample, check at the next falling edge.
    task automatic step(input bit iss, input bit dn, input int inc, input bit unc, input bit clr);
        v_cmd_issue  = iss;
        v_cmd_done   = dn;
        v_err_inc    = ERR_INC_W'(inc);
        v_err_uncorr = unc;
        v_clear      = clr;
        @(posedge v_clk0);
        model_update(iss, dn, inc, unc, clr);
        @(negedge v_clk0);
        compare_all();
        v_cmd_issue  = 0;
        v_cmd_done   = 0;
        v_err_inc    = '0;
        v_err_uncorr = 0;
        v_clear      = 0;
    endtask

    task automatic idle_until(input longint target);
        while (m_cyc < target) step(0, 0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_state"}, 64'(v_dbg_state), 64'd0);
        check_val({tag, "_cmd"}, 64'(v_dbg_cmd_cnt), 64'd0);
        check_val({tag, "_lat"}, v_dbg_latency_64, 64'd0);
        check_val({tag, "_err"}, v_dbg_err_64, 64'd0);
    endtask

    initial begin
        model_reset();
        // Reset state
        repeat (3) @(negedge v_clk0);
        check_all_zero("reset");
        v_rst0_n = 1;

        // Single command: issue at ts=10, done at ts=25
        idle_until(10);
        step(1, 0, 0, 0, 0);
        idle_until(25);
        step(0, 1, 0, 0, 0);
        check_val("t1_last", 64'(v_dbg_latency_64[31:0]), 64'd15);
        check_val("t1_max", 64'(v_dbg_latency_64[63:32]), 64'd15);
        check_val("t1_cmd", 64'(v_dbg_cmd_cnt), 64'd1);
        check_val("t1_state", 64'(v_dbg_state), 64'd0);

        // Three in-order commands
        idle_until(50);
        step(0, 0, 0, 0, 1);
        idle_until(100);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check_val("t2_occ3", 64'(v_dbg_state[8:4]), 64'd3);
        idle_until(110);
        step(0, 1, 0, 0, 0);
        check_val("t2_lat_a", 64'(v_dbg_latency_64[31:0]), 64'd10);
        idle_until(115);
        step(0, 1, 0, 0, 0);
        check_val("t2_lat_b", 64'(v_dbg_latency_64[31:0]), 64'd14);
        idle_until(130);
        step(0, 1, 0, 0, 0);
        check_val("t2_lat_c", 64'(v_dbg_latency_64[31:0]), 64'd28);
        check_val("t2_max", 64'(v_dbg_latency_64[63:32]), 64'd28);
        check_val("t2_cmd", 64'(v_dbg_cmd_cnt), 64'd3);
        check_val("t2_occ0", 64'(v_dbg_state[8:4]), 64'd0);

        // Fill, overflow, issue+done while full, clear
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 0);
        check_val("t3_full_state", 64'(v_dbg_state), 64'h0081);
        step(1, 0, 0, 0, 0);
        check_val("t3_ovf_state", 64'(v_dbg_state), 64'h0086);
        step(1, 1, 0, 0, 0);
        check_val("t3_both_full", 64'(v_dbg_state), 64'h0086);
        check_val("t3_both_cmd", 64'(v_dbg_cmd_cnt), 64'd1);
        step(0, 0, 0, 0, 1);
        check_all_zero("t3_clear");

        // Underflow cases
        step(0, 1, 0, 0, 0);
        check_val("t4_unf_state", 64'(v_dbg_state), 64'h000A);
        check_val("t4_unf_cmd", 64'(v_dbg_cmd_cnt), 64'd0);
        step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        check_val("t4_both_empty", 64'(v_dbg_state), 64'h001A);
        step(0, 0, 0, 0, 1);
        check_val("t4_clear", 64'(v_dbg_state), 64'd0);

        // Corrected-error saturation (preload near the top) and uncorrectable count
        force dut.r_err_corr = 48'hFFFF_FFFF_FFE0;
        m_corr = 64'h0000_FFFF_FFFF_FFE0;
        step(0, 0, 0, 0, 0);
        release dut.r_err_corr;
        for (int i = 0; i < 5; i++) step(0, 0, 15, 0, 0);
        check_val("t5_sat", 64'(v_dbg_err_64[47:0]), 64'h0000_FFFF_FFFF_FFFF);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        check_val("t5_uncorr", 64'(v_dbg_err_64[63:48]), 64'd3);

        // Timestamp wrap: move ts just below 2^32, then measure across the wrap
        step(0, 0, 0, 0, 1);
        force dut.r_ts = 32'hFFFF_FFF0;
        step(0, 0, 0, 0, 0);
        release dut.r_ts;
        step(1, 0, 0, 0, 0);
        repeat (31) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check_val("t6_wrap_lat", 64'(v_dbg_latency_64[31:0]), 64'h20);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 45,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0,
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 2);
        end

        // Asynchronous reset while active
        step(0, 0, 0, 0, 1);
        step(1, 0, 3, 1, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        #2;
        v_rst0_n = 0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge v_clk0);
        v_rst0_n = 1;
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
